// File: rtl/tetris_pkg.sv
// Shared Tetris constants: playfield geometry, line-clear engine encoding and game states.
// Also holds the saturating adder used for the cleared-lines total.
package tetris_pkg;

    localparam int ROWS    = 20;
    localparam int COLS    = 12;
    localparam int AW      = 5;
    localparam int TOTAL_W = 16;

    localparam logic [COLS-1:0] FULL_ROW = {COLS{1'b1}};
    localparam logic [AW-1:0]   ROWS_A   = AW'(ROWS);
    localparam logic [AW-1:0]   LAST_ROW = AW'(ROWS - 1);

    localparam logic [2:0] ENG_IDLE  = 3'd0;
    localparam logic [2:0] ENG_SCAN  = 3'd1;
    localparam logic [2:0] ENG_SHIFT = 3'd2;
    localparam logic [2:0] ENG_DONE  = 3'd3;
    localparam logic [2:0] ENG_WAIT  = 3'd4;

    localparam logic [1:0] STATE_TITLE = 2'd0;
    localparam logic [1:0] STATE_PLAY  = 2'd1;
    localparam logic [1:0] STATE_CLEAR = 2'd2;
    localparam logic [1:0] STATE_OVER  = 2'd3;

    function automatic logic [TOTAL_W-1:0] sat_add_total(input logic [TOTAL_W-1:0] a,
                                                         input logic [AW-1:0]      b);
        logic [TOTAL_W:0] sum;
        sum = {1'b0, a} + {{(TOTAL_W + 1 - AW){1'b0}}, b};
        if (sum[TOTAL_W]) begin
            return {TOTAL_W{1'b1}};
        end else begin
            return sum[TOTAL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/playfield_store_if.sv
// Game-logic / drawing-stage bus into the playfield store.
// PLAYFIELD_VBLANK_CLEAR_EN adds the vblank qualifier for the line-clear engine.
interface playfield_store_if;
    import tetris_pkg::*;

    logic [AW-1:0]      rd_addr;
    logic [COLS-1:0]    rd_data;
    logic [AW-1:0]      lg_rd_addr;
    logic [COLS-1:0]    lg_rd_data;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [COLS-1:0]    wr_data;
    logic               wipe;
    logic               clear_start;
    logic               clear_busy;
    logic               clear_done;
    logic [AW-1:0]      lines_cleared;
    logic [TOTAL_W-1:0] total_lines;
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
    logic               vblank;
`endif

    modport master (
        output rd_addr, lg_rd_addr, wr_en, wr_addr, wr_data, wipe, clear_start,
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
        output vblank,
`endif
        input  rd_data, lg_rd_data, clear_busy, clear_done, lines_cleared, total_lines
    );

    modport slave (
        input  rd_addr, lg_rd_addr, wr_en, wr_addr, wr_data, wipe, clear_start,
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
        input  vblank,
`endif
        output rd_data, lg_rd_data, clear_busy, clear_done, lines_cleared, total_lines
    );

endinterface

// File: rtl/playfield_clear_fsm.sv
// Line-clear sequencer: scans rows bottom-up and issues row-copy commands to the store.
// With PLAYFIELD_VBLANK_CLEAR_EN the scan is held in WAIT until vblank.
module playfield_clear_fsm
    import tetris_pkg::*;
(
    input  logic          vga_clk,
    input  logic          rst,
    input  logic          clear_start,
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
    input  logic          vblank,
`endif
    input  logic          row_full,
    output logic          idle,
    output logic          busy,
    output logic          done,
    output logic          shift_en,
    output logic [AW-1:0] scan_ptr,
    output logic [AW-1:0] shift_k,
    output logic [AW-1:0] cnt
);

    logic [2:0]    state_r, state_nxt_s;
    logic [AW-1:0] ptr_r, ptr_nxt_s;
    logic [AW-1:0] k_r, k_nxt_s;
    logic [AW-1:0] cnt_r, cnt_nxt_s;
    logic          busy_r, done_r;

    // Next-state and datapath decisions for the engine.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        k_nxt_s     = k_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ENG_IDLE: begin
                if (clear_start) begin
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
                    state_nxt_s = ENG_WAIT;
`else
                    state_nxt_s = ENG_SCAN;
`endif
                    ptr_nxt_s   = LAST_ROW;
                    cnt_nxt_s   = {AW{1'b0}};
                end else begin
                    state_nxt_s = ENG_IDLE;
                end
            end
            ENG_WAIT: begin
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
                if (vblank) begin
                    state_nxt_s = ENG_SCAN;
                end else begin
                    state_nxt_s = ENG_WAIT;
                end
`else
                state_nxt_s = ENG_IDLE;
`endif
            end
            ENG_SCAN: begin
                if (row_full) begin
                    state_nxt_s = ENG_SHIFT;
                    k_nxt_s     = ptr_r;
                end else if (ptr_r == {AW{1'b0}}) begin
                    state_nxt_s = ENG_DONE;
                end else begin
                    ptr_nxt_s   = ptr_r - 5'd1;
                end
            end
            ENG_SHIFT: begin
                // ptr stays put so the row that just dropped in is rechecked
                if (k_r == {AW{1'b0}}) begin
                    cnt_nxt_s   = cnt_r + 5'd1;
                    state_nxt_s = ENG_SCAN;
                end else begin
                    k_nxt_s     = k_r - 5'd1;
                end
            end
            ENG_DONE: begin
                state_nxt_s = ENG_IDLE;
            end
            default: begin
                state_nxt_s = ENG_IDLE;
            end
        endcase
    end

    // Engine state and status flags, registered from the next state.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_r <= ENG_IDLE;
            ptr_r   <= {AW{1'b0}};
            k_r     <= {AW{1'b0}};
            cnt_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            k_r     <= k_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s != ENG_IDLE);
            done_r  <= (state_nxt_s == ENG_DONE);
        end
    end

    assign idle     = (state_r == ENG_IDLE);
    assign busy     = busy_r;
    assign done     = done_r;
    assign shift_en = (state_r == ENG_SHIFT);
    assign scan_ptr = ptr_r;
    assign shift_k  = k_r;
    assign cnt      = cnt_r;

endmodule

// File: rtl/playfield_store.sv
// 20x12 Tetris playfield with two registered read ports, a game-logic write port and line clear.
// Build with PLAYFIELD_VBLANK_CLEAR_EN to start line clears only during vblank.
module playfield_store
    import tetris_pkg::*;
(
    input logic              vga_clk,
    input logic              rst,
    playfield_store_if.slave bus
);

    logic [COLS-1:0]    rows_r [ROWS];
    logic [COLS-1:0]    rd_data_r, lg_rd_data_r;
    logic [AW-1:0]      lines_cleared_r;
    logic [TOTAL_W-1:0] total_lines_r;

    logic          idle_s, busy_s, done_s, shift_en_s, row_full_s;
    logic          wr_ok_s, wipe_ok_s;
    logic [AW-1:0] scan_ptr_s, shift_k_s, cnt_s;

    assign row_full_s = (rows_r[scan_ptr_s] == FULL_ROW);
    assign wipe_ok_s  = bus.wipe && idle_s;
    assign wr_ok_s    = bus.wr_en && idle_s && (bus.wr_addr < ROWS_A);

    playfield_clear_fsm u_clear_fsm (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .clear_start (bus.clear_start),
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
        .vblank      (bus.vblank),
`endif
        .row_full    (row_full_s),
        .idle        (idle_s),
        .busy        (busy_s),
        .done        (done_s),
        .shift_en    (shift_en_s),
        .scan_ptr    (scan_ptr_s),
        .shift_k     (shift_k_s),
        .cnt         (cnt_s)
    );

    // Row storage: reset/wipe zero the field, writes only land while the engine is idle.
    always_ff @(posedge vga_clk) begin
        if (rst || wipe_ok_s) begin
            for (int i = 0; i < ROWS; i++) begin
                rows_r[i] <= {COLS{1'b0}};
            end
        end else if (wr_ok_s) begin
            rows_r[bus.wr_addr] <= bus.wr_data;
        end else if (shift_en_s) begin
            rows_r[shift_k_s] <= (shift_k_s == {AW{1'b0}}) ? {COLS{1'b0}}
                                                           : rows_r[shift_k_s - 5'd1];
        end else begin
            rows_r <= rows_r;
        end
    end

    // Both read ports: one-cycle latency, out-of-range rows read as empty.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rd_data_r    <= {COLS{1'b0}};
            lg_rd_data_r <= {COLS{1'b0}};
        end else begin
            rd_data_r    <= (bus.rd_addr < ROWS_A) ? rows_r[bus.rd_addr] : {COLS{1'b0}};
            lg_rd_data_r <= (bus.lg_rd_addr < ROWS_A) ? rows_r[bus.lg_rd_addr] : {COLS{1'b0}};
        end
    end

    // Cleared-line statistics; wipe restarts the total but keeps the last run's count.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            lines_cleared_r <= {AW{1'b0}};
            total_lines_r   <= {TOTAL_W{1'b0}};
        end else if (wipe_ok_s) begin
            total_lines_r   <= {TOTAL_W{1'b0}};
        end else if (done_s) begin
            lines_cleared_r <= cnt_s;
            total_lines_r   <= sat_add_total(total_lines_r, cnt_s);
        end else begin
            lines_cleared_r <= lines_cleared_r;
            total_lines_r   <= total_lines_r;
        end
    end

    assign bus.rd_data       = rd_data_r;
    assign bus.lg_rd_data    = lg_rd_data_r;
    assign bus.clear_busy    = busy_s;
    assign bus.clear_done    = done_s;
    assign bus.lines_cleared = lines_cleared_r;
    assign bus.total_lines   = total_lines_r;

endmodule

// File: tb/tb_playfield_store.sv
// Scoreboard bench for playfield_store: reads and clear completions are checked by a monitor.
// Also exercises the vblank gating when PLAYFIELD_VBLANK_CLEAR_EN is defined.
module tb_playfield_store;
    import tetris_pkg::*;

    logic vga_clk = 1'b0;
    logic rst;
    always #5 vga_clk = ~vga_clk;

    playfield_store_if bus();
    playfield_store dut (.vga_clk(vga_clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [AW-1:0]   addr;
        logic [COLS-1:0] exp;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0]      lines;
        logic [TOTAL_W-1:0] total;
        int                 lat;
    } done_exp_t;

`ifdef PLAYFIELD_VBLANK_CLEAR_EN
    localparam int EMPTY_LAT = 22;
`else
    localparam int EMPTY_LAT = 21;
`endif

    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic rd_issue = 1'b0, rd_valid = 1'b0, done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge vga_clk) begin
        cyc      <= cyc + 1;
        rd_valid <= rd_issue;
    end

    // Monitor: pops the scoreboard whenever read data or a clear completion appears.
    always @(negedge vga_clk) begin
        rd_exp_t   re;
        done_exp_t de;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                re = rd_q.pop_front();
                chk($sformatf("rd_data[%0d]", re.addr), 32'(bus.rd_data), 32'(re.exp));
                chk($sformatf("lg_rd_data[%0d]", re.addr), 32'(bus.lg_rd_data), 32'(re.exp));
            end
        end
        if (done_prev) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                de = done_q.pop_front();
                chk("lines_cleared", 32'(bus.lines_cleared), 32'(de.lines));
                chk("total_lines", 32'(bus.total_lines), 32'(de.total));
                if (de.lat >= 0) chk("done_latency", 32'(done_cyc - start_cyc), 32'(de.lat));
            end
        end
        done_prev = bus.clear_done;
        if (bus.clear_done) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [COLS-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input logic [COLS-1:0] e);
        rd_exp_t re;
        re.addr = a; re.exp = e;
        rd_q.push_back(re);
        bus.rd_addr = a; bus.lg_rd_addr = a; rd_issue = 1'b1;
        step();
        rd_issue = 1'b0;
    endtask

    task automatic expect_done(input logic [AW-1:0] l, input logic [TOTAL_W-1:0] t, input int lat);
        done_exp_t de;
        de.lines = l; de.total = t; de.lat = lat;
        done_q.push_back(de);
    endtask

    task automatic start_clear();
        bus.clear_start = 1'b1;
        start_cyc = cyc;
        step();
        bus.clear_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.clear_busy && n < budget) begin
            step();
            n++;
        end
        if (bus.clear_busy) chk("clear_timeout", 32'd1, 32'd0);
        step();
    endtask

    initial begin
        int d0;
        bus.rd_addr = '0; bus.lg_rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.wipe = 1'b0; bus.clear_start = 1'b0;
`ifdef PLAYFIELD_VBLANK_CLEAR_EN
        bus.vblank = 1'b1;
`endif
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_busy", 32'(bus.clear_busy), 32'd0);
        chk("reset_done", 32'(bus.clear_done), 32'd0);
        chk("reset_total", 32'(bus.total_lines), 32'd0);
        chk("reset_lines", 32'(bus.lines_cleared), 32'd0);
        for (int r = 0; r < 20; r++) rd_chk(5'(r), 12'h000);
        rd_chk(5'd25, 12'h000);

        // basic write/read, out-of-range writes ignored
        wr(5'd7, 12'hA5A);
        wr(5'd20, 12'hFFF);
        wr(5'd31, 12'hFFF);
        rd_chk(5'd7, 12'hA5A);
        rd_chk(5'd6, 12'h000);
        rd_chk(5'd20, 12'h000);
        wr(5'd7, 12'h000);

        // two full rows at the bottom; writes and wipe during the run are dropped
        wr(5'd17, 12'h801); wr(5'd18, 12'hFFF); wr(5'd19, 12'hFFF);
        d0 = done_cnt;
        expect_done(5'd2, 16'd2, -1);
        start_clear();
        chk("busy_after_start", 32'(bus.clear_busy), 32'd1);
        wr(5'd0, 12'hFFF);
        bus.wipe = 1'b1; step(); bus.wipe = 1'b0;
        wait_idle(200);
        chk("done_pulses_two_rows", 32'(done_cnt - d0), 32'd1);
        for (int r = 0; r < 19; r++) rd_chk(5'(r), 12'h000);
        rd_chk(5'd19, 12'h801);

        // tetris: four full rows, stack above drops by four
        for (int r = 0; r < 16; r++) wr(5'(r), 12'h3A5 + 12'(r));
        for (int r = 16; r < 20; r++) wr(5'(r), 12'hFFF);
        expect_done(5'd4, 16'd6, -1);
        start_clear();
        wait_idle(400);
        for (int r = 0; r < 4; r++) rd_chk(5'(r), 12'h000);
        for (int r = 4; r < 20; r++) rd_chk(5'(r), 12'h3A5 + 12'(r - 4));

        // reset while shifting aborts the run
        wr(5'd19, 12'hFFF);
        d0 = done_cnt;
        start_clear();
        step();
        chk("busy_in_shift", 32'(bus.clear_busy), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("abort_busy", 32'(bus.clear_busy), 32'd0);
        chk("abort_total", 32'(bus.total_lines), 32'd0);
        chk("abort_lines", 32'(bus.lines_cleared), 32'd0);
        for (int r = 0; r < 20; r++) rd_chk(5'(r), 12'h000);
        repeat (30) step();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // single line, then wipe keeps lines_cleared but zeroes total and rows
        wr(5'd19, 12'hFFF);
        expect_done(5'd1, 16'd1, -1);
        start_clear();
        wait_idle(200);
        wr(5'd5, 12'h0F0);
        bus.wipe = 1'b1; step(); bus.wipe = 1'b0;
        chk("wipe_total", 32'(bus.total_lines), 32'd0);
        chk("wipe_lines_held", 32'(bus.lines_cleared), 32'd1);
        rd_chk(5'd5, 12'h000);

        // empty field: fixed latency, second request while busy ignored
        expect_done(5'd0, 16'd0, EMPTY_LAT);
        start_clear();
        repeat (4) step();
        bus.clear_start = 1'b1; step(); bus.clear_start = 1'b0;
        wait_idle(200);

`ifdef PLAYFIELD_VBLANK_CLEAR_EN
        // scan must not start until vblank
        bus.vblank = 1'b0;
        wr(5'd19, 12'hFFF);
        expect_done(5'd1, 16'd1, -1);
        start_clear();
        repeat (100) step();
        chk("vblank_wait_busy", 32'(bus.clear_busy), 32'd1);
        rd_chk(5'd19, 12'hFFF);
        bus.vblank = 1'b1;
        wait_idle(200);
        rd_chk(5'd19, 12'h000);
`endif

        repeat (3) step();
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
